// File: rtl/multi_range_finder.sv
// multi_range_finder: tracks the running minimum and maximum of CHANNELS parallel sample lanes.
// One go/finish sequence is shared by all lanes. Each sequence selects unsigned or signed
// comparison when it starts. At finish the block commits per-lane range, min and max, plus a
// saturating sample count, and pulses done for one cycle.
//
// Ports:
//   clock, reset   rising-edge clock; asynchronous active-high reset
//   data_in        CHANNELS packed samples, lane k at [k*WIDTH +: WIDTH]
//   valid          data_in carries a sample this cycle
//   go             first sample of a sequence (must come with valid)
//   finish         end of sequence; with valid, data_in is the last sample
//   signed_mode    1 = two's-complement compare, latched on an accepted go
//   range          per-lane max-min, WIDTH+1 bits per lane
//   min_out        committed per-lane minimum
//   max_out        committed per-lane maximum
//   count          samples in the last completed sequence (saturating)
//   busy           sequence in progress
//   done           one-cycle pulse when results update
//   error          protocol violation, held until a clean restart
module multi_range_finder #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WIDTH*CHANNELS-1:0]     data_in,
    input  logic                          valid,
    input  logic                          go,
    input  logic                          finish,
    input  logic                          signed_mode,
    output logic [(WIDTH+1)*CHANNELS-1:0] range,
    output logic [WIDTH*CHANNELS-1:0]     min_out,
    output logic [WIDTH*CHANNELS-1:0]     max_out,
    output logic [CNT_WIDTH-1:0]          count,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int unsigned RW = WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone, StError} state_e;

    state_e                     state_q, state_d;
    logic [WIDTH*CHANNELS-1:0]  run_min_q, run_min_d, run_max_q, run_max_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                       signed_q, signed_d;
    logic [RW*CHANNELS-1:0]     range_q, range_d;
    logic [WIDTH*CHANNELS-1:0]  min_out_q, min_out_d, max_out_q, max_out_d;
    logic [CNT_WIDTH-1:0]       count_q, count_d;

    // Running extremes with this cycle's sample folded in (if valid), and their range.
    logic [WIDTH*CHANNELS-1:0]  upd_min, upd_max;
    logic [RW*CHANNELS-1:0]     upd_range;

    logic load;
    assign load = go & valid & ~finish;

    // Flipping the MSB turns a two's-complement compare into an unsigned one.
    function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic sgn);
        logic [WIDTH-1:0] ab, bb;
        ab = a;
        bb = b;
        ab[WIDTH-1] = a[WIDTH-1] ^ sgn;
        bb[WIDTH-1] = b[WIDTH-1] ^ sgn;
        return ab < bb;
    endfunction

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    always_comb begin
        upd_min   = run_min_q;
        upd_max   = run_max_q;
        upd_range = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            logic [WIDTH-1:0] smp, mn, mx;
            logic [RW-1:0]    ext_mn, ext_mx;
            smp = data_in[k*WIDTH +: WIDTH];
            mn  = run_min_q[k*WIDTH +: WIDTH];
            mx  = run_max_q[k*WIDTH +: WIDTH];
            if (valid) begin
                if (less_than(smp, mn, signed_q)) mn = smp;
                if (less_than(mx, smp, signed_q)) mx = smp;
            end
            // Sign- or zero-extend to WIDTH+1 so the difference is always exact and >= 0.
            ext_mn = {signed_q & mn[WIDTH-1], mn};
            ext_mx = {signed_q & mx[WIDTH-1], mx};
            upd_min[k*WIDTH +: WIDTH] = mn;
            upd_max[k*WIDTH +: WIDTH] = mx;
            upd_range[k*RW +: RW]     = ext_mx - ext_mn;
        end
    end

    always_comb begin
        logic enter_error;
        state_d     = state_q;
        run_min_d   = run_min_q;
        run_max_d   = run_max_q;
        cnt_d       = cnt_q;
        signed_d    = signed_q;
        range_d     = range_q;
        min_out_d   = min_out_q;
        max_out_d   = max_out_q;
        count_d     = count_q;
        enter_error = 1'b0;

        case (state_q)
            StIdle, StError: begin
                if (load) begin
                    state_d   = StRun;
                    run_min_d = data_in;
                    run_max_d = data_in;
                    cnt_d     = CNT_WIDTH'(1);
                    signed_d  = signed_mode;
                end else if (state_q == StIdle && (finish || go)) begin
                    enter_error = 1'b1;
                end
            end
            StRun: begin
                if (go) begin
                    enter_error = 1'b1;
                end else if (finish) begin
                    state_d   = StDone;
                    range_d   = upd_range;
                    min_out_d = upd_min;
                    max_out_d = upd_max;
                    count_d   = valid ? cnt_inc : cnt_q;
                end else if (valid) begin
                    run_min_d = upd_min;
                    run_max_d = upd_max;
                    cnt_d     = cnt_inc;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (enter_error) begin
            state_d   = StError;
            range_d   = '0;
            min_out_d = '0;
            max_out_d = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            run_min_q <= '0;
            run_max_q <= '0;
            cnt_q     <= '0;
            signed_q  <= 1'b0;
            range_q   <= '0;
            min_out_q <= '0;
            max_out_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            cnt_q     <= cnt_d;
            signed_q  <= signed_d;
            range_q   <= range_d;
            min_out_q <= min_out_d;
            max_out_q <= max_out_d;
            count_q   <= count_d;
        end
    end

    assign range   = range_q;
    assign min_out = min_out_q;
    assign max_out = max_out_q;
    assign count   = count_q;
    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign error   = (state_q == StError);

endmodule
